counter_up_period: RTL and testbench



---
 rtl/counter_up_period_if.sv | 37 +++
 rtl/counter_up_period.sv | 68 ++++++
 tb/tb_counter_up_period.sv | 125 ++++++++++++
 3 files changed

// File: rtl/counter_up_period_if.sv
// counter_up_period_if
//   Bundles the counter's programming input and its count/strobe outputs.
//   master : the block that programs the period and consumes the timebase.
//   slave  : the counter itself.
// Signals:
//   counterPeriod  period in clock ticks (0 parks the counter).
//   countedUpTo    current count, registered.
//   wrapPulse      one-cycle strobe, high while countedUpTo has just wrapped to 0.
//   wrapCount      saturating wrap tally, present only with COUNTER_UP_WRAP_COUNT_EN.
interface counter_up_period_if #(
  parameter int WIDTH = 28
);
  logic [WIDTH-1:0] counterPeriod;
  logic [WIDTH-1:0] countedUpTo;
  logic             wrapPulse;
`ifdef COUNTER_UP_WRAP_COUNT_EN
  logic [15:0]      wrapCount;
`endif

  modport master (
    output counterPeriod,
    input  countedUpTo,
    input  wrapPulse
`ifdef COUNTER_UP_WRAP_COUNT_EN
   ,input  wrapCount
`endif
  );

  modport slave (
    input  counterPeriod,
    output countedUpTo,
    output wrapPulse
`ifdef COUNTER_UP_WRAP_COUNT_EN
   ,output wrapCount
`endif
  );
endinterface

// File: rtl/counter_up_period.sv
// counter_up_period
//   Free-running modulo-N up-counter with a runtime-programmable period.
//   Counts 0 .. counterPeriod-1, then wraps to 0 and raises wrapPulse for
//   that one cycle. Serves as the timebase for PWM generators.
// Ports:
//   clock  system clock, all state on its rising edge.
//   reset  asynchronous, active-low reset.
//   bus    counter_up_period_if.slave (counterPeriod in, countedUpTo/wrapPulse out).
// Optional feature (macro COUNTER_UP_WRAP_COUNT_EN):
//   adds bus.wrapCount, a 16-bit count of wraps that saturates at 16'hFFFF
//   and is cleared only by reset. Undefined: no port, no logic.
module counter_up_period #(
  parameter int WIDTH = 28
) (
  input  logic                 clock,
  input  logic                 reset,
  counter_up_period_if.slave   bus
);

  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic [WIDTH-1:0] last;
  logic             parked;
  logic             term;

  // A zero period would underflow last; parked masks that case so the
  // compare never sees the wrapped-around all-ones value.
  assign parked = (bus.counterPeriod == '0);
  assign last   = bus.counterPeriod - WIDTH'(1);
  // >= rather than == so a period lowered below the current count wraps
  // on the next edge instead of running on through 2^WIDTH.
  assign term   = !parked && (cnt >= last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (parked) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (term) begin
      cnt  <= '0;
      wrap <= 1'b1;
    end else begin
      cnt  <= cnt + WIDTH'(1);
      wrap <= 1'b0;
    end
  end

  assign bus.countedUpTo = cnt;
  assign bus.wrapPulse   = wrap;

`ifdef COUNTER_UP_WRAP_COUNT_EN
  logic [15:0] wcnt;

  // Counts on the same edge that sets wrapPulse, so it always equals the
  // number of strobes issued so far (until it saturates).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      wcnt <= '0;
    else if (term && (wcnt != 16'hFFFF))
      wcnt <= wcnt + 16'd1;
  end

  assign bus.wrapCount = wcnt;
`endif

endmodule

// File: tb/tb_counter_up_period.sv
module tb_counter_up_period;
  localparam int W = 28;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Reference state: plain integers following the counting rules.
  longint m_cnt  = 0;
  bit     m_wrap = 0;
  int     m_wc   = 0;

  counter_up_period_if #(.WIDTH(W)) bus ();
  counter_up_period #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, longint'(bus.countedUpTo), m_cnt);
    chk({tag, ".wrap"}, longint'(bus.wrapPulse), longint'(m_wrap));
`ifdef COUNTER_UP_WRAP_COUNT_EN
    chk({tag, ".wcount"}, longint'(bus.wrapCount), longint'(m_wc));
`endif
  endtask

  // Drive the period, take one rising edge, advance the model, check at +1.
  task automatic cyc(input longint p, input string tag);
    bus.counterPeriod = p[W-1:0];
    @(posedge clock);
    if (!reset) begin
      m_cnt = 0; m_wrap = 0;
    end else if (p == 0) begin
      m_cnt = 0; m_wrap = 0;
    end else if (m_cnt + 1 >= p) begin
      m_cnt = 0; m_wrap = 1;
      if (m_wc < 65535) m_wc++;
    end else begin
      m_cnt = m_cnt + 1; m_wrap = 0;
    end
    #1;
    check_all(tag);
  endtask

  // Run at period p until the model count reaches target, bounded.
  task automatic run_to(input longint p, input longint target, input string tag);
    int n = 0;
    while (m_cnt != target && n < 1000) begin
      cyc(p, tag);
      n++;
    end
    chk({tag, ".reached"}, m_cnt, target);
  endtask

  initial begin
    bus.counterPeriod = W'(5);
    #1;
    check_all("reset_async");
    // Hold reset through three edges.
    for (int i = 0; i < 3; i++) cyc(5, "reset_hold");
    reset = 1'b1;
    // Expect 1,2,3,4,0,1,... with a strobe on each 0.
    for (int i = 0; i < 12; i++) cyc(5, "p5");

    // Asynchronous reset between edges while count is 3.
    run_to(5, 3, "pre_async");
    #2 reset = 1'b0;
    #1;
    m_cnt = 0; m_wrap = 0; m_wc = 0;
    check_all("async_rst");
    @(negedge clock);
    cyc(5, "async_hold");
    reset = 1'b1;
    for (int i = 0; i < 7; i++) cyc(5, "after_async");

    // Parked, then period 1.
    for (int i = 0; i < 5; i++) cyc(0, "p0");
    for (int i = 0; i < 5; i++) cyc(1, "p1");

    // Shrink below current count.
    run_to(100, 60, "shrink_pre");
    for (int i = 0; i < 22; i++) cyc(10, "shrink");

    // Grow mid-cycle.
    run_to(10, 7, "grow_pre");
    for (int i = 0; i < 25; i++) cyc(20, "grow");

    // Large period: two full cycles plus one.
    for (int i = 0; i < 40001; i++) cyc(20000, "large");

    // Randomized period changes, including occasional wide values.
    begin
      longint p = 7;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: p = 0;
            1: p = $urandom_range(1, 3);
            2: p = $urandom_range(4, 40);
            default: p = longint'($urandom) & 64'h0FFF_FFFF;
          endcase
        end
        cyc(p, "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
